mem_port_arbiter: RTL and testbench

//  Two-requester round-robin arbiter/sequencer for the single CPU memory port
//  (memWe/memRd/memAdr/memwrData/memrdData). It sits between requester 0
//  (instruction fetch) and requester 1 (load/store) and the memory. It serialises
//  one transaction at a time, times the fixed read latency and returns a one-cycle response.

---
 rtl/mem_port_arbiter_if.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Request/response/memory bundle for the two-requester memory port arbiter.
// Handshake: a request transfers on a cycle where reqN_valid && reqN_ready; the
// requester holds valid and its payload stable until then, and rspN_valid is a
// single-cycle completion pulse with no back-pressure.
interface mem_port_arbiter_if #(
  parameter int PC_WIDTH  = 32,
  parameter int REG_WIDTH = 32
);
  logic                 req0_valid;
  logic                 req0_we;
  logic [PC_WIDTH-1:0]  req0_addr;
  logic [REG_WIDTH-1:0] req0_wdata;
  logic                 req0_ready;
  logic                 rsp0_valid;
  logic [REG_WIDTH-1:0] rsp0_rdata;

  logic                 req1_valid;
  logic                 req1_we;
  logic [PC_WIDTH-1:0]  req1_addr;
  logic [REG_WIDTH-1:0] req1_wdata;
  logic                 req1_ready;
  logic                 rsp1_valid;
  logic [REG_WIDTH-1:0] rsp1_rdata;

  logic                 memWe;
  logic                 memRd;
  logic [PC_WIDTH-1:0]  memAdr;
  logic [REG_WIDTH-1:0] memwrData;
  logic [REG_WIDTH-1:0] memrdData;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    input  memrdData,
    output req0_ready, rsp0_valid, rsp0_rdata,
    output req1_ready, rsp1_valid, rsp1_rdata,
    output memWe, memRd, memAdr, memwrData
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    output memrdData,
    input  req0_ready, rsp0_valid, rsp0_rdata,
    input  req1_ready, rsp1_valid, rsp1_rdata,
    input  memWe, memRd, memAdr, memwrData
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter/sequencer sharing one memory port between instruction
// fetch (requester 0) and load/store (requester 1), one transaction at a time.
module mem_port_arbiter #(
  parameter int PC_WIDTH   = 32,
  parameter int REG_WIDTH  = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus,
  output logic                resetn,
  output logic                busy,
  output logic [1:0]          o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam int LAT_W = $clog2(RD_LATENCY + 1);
  localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(RD_LATENCY);

  state_t               r_state;
  state_t               w_next_state;
  logic                 r_last_gnt;
  logic                 r_id;
  logic                 r_we;
  logic [PC_WIDTH-1:0]  r_addr;
  logic [REG_WIDTH-1:0] r_wdata;
  logic [REG_WIDTH-1:0] r_rdata_q;
  logic [LAT_W-1:0]     r_lat_cnt;
  logic                 r_resetn;

  logic                 w_any_valid;
  logic                 w_gnt_id;
  logic                 w_accept;
  logic                 w_lat_done;
  logic [REG_WIDTH-1:0] w_rsp_data;

  // With both requesters pending, the one not served last wins.
  always_comb begin
    w_any_valid = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      w_gnt_id = ~r_last_gnt;
    end else begin
      w_gnt_id = bus.req1_valid;
    end
    w_accept   = (r_state == S_IDLE) && w_any_valid;
    w_lat_done = (r_lat_cnt == LAT_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next_state = S_ISSUE;
      S_ISSUE: w_next_state = r_we ? S_RESP : S_WAIT;
      S_WAIT:  if (w_lat_done) w_next_state = S_RESP;
      S_RESP:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Request latch doubles as memAdr/memwrData, which must hold between issues.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_gnt <= 1'b1;
      r_id       <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata_q  <= '0;
      r_lat_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_id       <= w_gnt_id;
        r_last_gnt <= w_gnt_id;
        r_we       <= w_gnt_id ? bus.req1_we : bus.req0_we;
        r_addr     <= w_gnt_id ? bus.req1_addr : bus.req0_addr;
        if (w_gnt_id ? bus.req1_we : bus.req0_we) begin
          r_wdata <= w_gnt_id ? bus.req1_wdata : bus.req0_wdata;
        end
      end
      if (r_state == S_ISSUE && !r_we) begin
        r_lat_cnt <= LAT_W'(1);
      end else if (r_state == S_WAIT) begin
        r_lat_cnt <= w_lat_done ? '0 : r_lat_cnt + LAT_W'(1);
      end
      if (r_state == S_WAIT && w_lat_done) begin
        r_rdata_q <= bus.memrdData;
      end
    end
  end

  always_ff @(posedge clk) begin
    r_resetn <= ~reset;
  end

  always_comb begin
    w_rsp_data     = r_we ? '0 : r_rdata_q;
    bus.req0_ready = (r_state == S_IDLE) && bus.req0_valid && !w_gnt_id;
    bus.req1_ready = (r_state == S_IDLE) && bus.req1_valid && w_gnt_id;
    bus.memWe      = (r_state == S_ISSUE) && r_we;
    bus.memRd      = (r_state == S_ISSUE) && !r_we;
    bus.memAdr     = r_addr;
    bus.memwrData  = r_wdata;
    bus.rsp0_valid = (r_state == S_RESP) && !r_id;
    bus.rsp1_valid = (r_state == S_RESP) && r_id;
    bus.rsp0_rdata = bus.rsp0_valid ? w_rsp_data : '0;
    bus.rsp1_rdata = bus.rsp1_valid ? w_rsp_data : '0;
    busy           = (r_state != S_IDLE);
    resetn         = r_resetn;
    o_dbg_state    = r_state;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(bus.req0_ready && bus.req1_ready));
      assert (!(bus.memWe && bus.memRd));
      assert (r_lat_cnt <= LAT_MAX);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one DUT at read latency 1, one at 3.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.PC_WIDTH(32), .REG_WIDTH(32)) b1 ();
  mem_port_arbiter_if #(.PC_WIDTH(32), .REG_WIDTH(32)) b3 ();

  logic       resetn1, busy1, resetn3, busy3;
  logic [1:0] st1, st3;

  mem_port_arbiter #(.PC_WIDTH(32), .REG_WIDTH(32), .RD_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .bus(b1.slave),
    .resetn(resetn1), .busy(busy1), .o_dbg_state(st1)
  );

  mem_port_arbiter #(.PC_WIDTH(32), .REG_WIDTH(32), .RD_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .bus(b3.slave),
    .resetn(resetn3), .busy(busy3), .o_dbg_state(st3)
  );

  // ---------------- clock / phase helpers ----------------
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    b1.req0_valid = 0; b1.req0_we = 0; b1.req0_addr = 0; b1.req0_wdata = 0;
    b1.req1_valid = 0; b1.req1_we = 0; b1.req1_addr = 0; b1.req1_wdata = 0;
    b1.memrdData  = 0;
    b3.req0_valid = 0; b3.req0_we = 0; b3.req0_addr = 0; b3.req0_wdata = 0;
    b3.req1_valid = 0; b3.req1_we = 0; b3.req1_addr = 0; b3.req1_wdata = 0;
    b3.memrdData  = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    mid();
    total++; if (b1.memWe !== 1'b0) begin bad++; $display("FAIL rst_memWe: got=%b exp=0", b1.memWe); end
    total++; if (b1.memRd !== 1'b0) begin bad++; $display("FAIL rst_memRd: got=%b exp=0", b1.memRd); end
    total++; if (b1.memAdr !== 32'h0) begin bad++; $display("FAIL rst_memAdr: got=%h exp=0", b1.memAdr); end
    total++; if (b1.memwrData !== 32'h0) begin bad++; $display("FAIL rst_memwrData: got=%h exp=0", b1.memwrData); end
    total++; if ({b1.rsp0_valid, b1.rsp1_valid} !== 2'b00) begin bad++; $display("FAIL rst_rsp_valid: got=%b exp=00", {b1.rsp0_valid, b1.rsp1_valid}); end
    total++; if (b1.rsp0_rdata !== 32'h0) begin bad++; $display("FAIL rst_rsp0_rdata: got=%h exp=0", b1.rsp0_rdata); end
    total++; if (resetn1 !== 1'b0) begin bad++; $display("FAIL rst_resetn: got=%b exp=0", resetn1); end
    total++; if (busy1 !== 1'b0 || st1 !== 2'd0) begin bad++; $display("FAIL rst_state: got busy=%b st=%0d exp busy=0 st=0", busy1, st1); end
    nxt();
    reset = 0;
    mid();
    total++; if (resetn1 !== 1'b0) begin bad++; $display("FAIL rel_resetn_hold: got=%b exp=0", resetn1); end
    nxt();
    mid();
    total++; if (resetn1 !== 1'b1) begin bad++; $display("FAIL rel_resetn_rise: got=%b exp=1", resetn1); end
  endtask

  task automatic test_read_lat1();
    nxt();
    b1.req0_valid = 1; b1.req0_we = 0; b1.req0_addr = 32'h10; b1.memrdData = 32'hBAD0BAD0;
    mid();
    total++; if ({b1.req0_ready, b1.req1_ready} !== 2'b10) begin bad++; $display("FAIL rd1_ready: got=%b exp=10", {b1.req0_ready, b1.req1_ready}); end
    nxt();
    b1.req0_valid = 0;
    mid();
    total++; if (b1.memRd !== 1'b1 || b1.memWe !== 1'b0) begin bad++; $display("FAIL rd1_strobe: got rd=%b we=%b exp rd=1 we=0", b1.memRd, b1.memWe); end
    total++; if (b1.memAdr !== 32'h10) begin bad++; $display("FAIL rd1_addr: got=%h exp=10", b1.memAdr); end
    nxt();
    b1.memrdData = 32'hDEADBEEF;
    mid();
    total++; if (b1.memRd !== 1'b0 || b1.rsp0_valid !== 1'b0) begin bad++; $display("FAIL rd1_wait: got rd=%b rsp0=%b exp 0 0", b1.memRd, b1.rsp0_valid); end
    nxt();
    b1.memrdData = 32'hBAD0BAD0;
    mid();
    total++; if (b1.rsp0_valid !== 1'b1 || b1.rsp1_valid !== 1'b0) begin bad++; $display("FAIL rd1_rsp_valid: got rsp0=%b rsp1=%b exp 1 0", b1.rsp0_valid, b1.rsp1_valid); end
    total++; if (b1.rsp0_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd1_rdata: got=%h exp=deadbeef", b1.rsp0_rdata); end
    nxt();
    mid();
    total++; if (busy1 !== 1'b0 || b1.rsp0_valid !== 1'b0) begin bad++; $display("FAIL rd1_done: got busy=%b rsp0=%b exp 0 0", busy1, b1.rsp0_valid); end
  endtask

  task automatic test_write_req1();
    nxt();
    b1.req1_valid = 1; b1.req1_we = 1; b1.req1_addr = 32'h20; b1.req1_wdata = 32'h1234;
    mid();
    total++; if ({b1.req0_ready, b1.req1_ready} !== 2'b01) begin bad++; $display("FAIL wr_ready: got=%b exp=01", {b1.req0_ready, b1.req1_ready}); end
    nxt();
    b1.req1_valid = 0;
    mid();
    total++; if (b1.memWe !== 1'b1 || b1.memRd !== 1'b0) begin bad++; $display("FAIL wr_strobe: got we=%b rd=%b exp we=1 rd=0", b1.memWe, b1.memRd); end
    total++; if (b1.memAdr !== 32'h20 || b1.memwrData !== 32'h1234) begin bad++; $display("FAIL wr_bus: got adr=%h data=%h exp 20 1234", b1.memAdr, b1.memwrData); end
    nxt();
    mid();
    total++; if (b1.rsp1_valid !== 1'b1 || b1.rsp0_valid !== 1'b0 || b1.memWe !== 1'b0) begin bad++; $display("FAIL wr_rsp: got rsp1=%b rsp0=%b we=%b exp 1 0 0", b1.rsp1_valid, b1.rsp0_valid, b1.memWe); end
    total++; if (b1.rsp1_rdata !== 32'h0) begin bad++; $display("FAIL wr_rdata: got=%h exp=0", b1.rsp1_rdata); end
    nxt();
    mid();
    total++; if (busy1 !== 1'b0 || b1.memAdr !== 32'h20 || b1.memwrData !== 32'h1234) begin bad++; $display("FAIL wr_hold: got busy=%b adr=%h data=%h exp 0 20 1234", busy1, b1.memAdr, b1.memwrData); end
  endtask

  task automatic test_round_robin();
    logic e0, e1, er0, er1;
    nxt();
    reset = 1;
    nxt();
    reset = 0;
    b1.req0_valid = 1; b1.req0_we = 1; b1.req0_addr = 32'hA0; b1.req0_wdata = 32'h1;
    b1.req1_valid = 1; b1.req1_we = 1; b1.req1_addr = 32'hB0; b1.req1_wdata = 32'h2;
    for (int k = 0; k < 12; k++) begin
      mid();
      e0 = (k % 6 == 0); e1 = (k % 6 == 3);
      er0 = (k % 6 == 2); er1 = (k % 6 == 5);
      total++; if ({b1.req0_ready, b1.req1_ready} !== {e0, e1}) begin bad++; $display("FAIL rr_grant k=%0d: got=%b exp=%b", k, {b1.req0_ready, b1.req1_ready}, {e0, e1}); end
      total++; if ({b1.rsp0_valid, b1.rsp1_valid} !== {er0, er1}) begin bad++; $display("FAIL rr_rsp k=%0d: got=%b exp=%b", k, {b1.rsp0_valid, b1.rsp1_valid}, {er0, er1}); end
      if (k % 6 == 1) begin
        total++; if (b1.memWe !== 1'b1 || b1.memAdr !== 32'hA0) begin bad++; $display("FAIL rr_issue0 k=%0d: got we=%b adr=%h exp 1 a0", k, b1.memWe, b1.memAdr); end
      end
      if (k % 6 == 4) begin
        total++; if (b1.memWe !== 1'b1 || b1.memAdr !== 32'hB0) begin bad++; $display("FAIL rr_issue1 k=%0d: got we=%b adr=%h exp 1 b0", k, b1.memWe, b1.memAdr); end
      end
      nxt();
    end
    b1.req0_valid = 0; b1.req1_valid = 0;
    mid();
  endtask

  task automatic test_read_lat3();
    logic e_rd, e_rsp, e_busy;
    nxt();
    b3.req1_valid = 1; b3.req1_we = 0; b3.req1_addr = 32'h40; b3.memrdData = 32'hBAD0BAD0;
    mid();
    total++; if (b3.req1_ready !== 1'b1) begin bad++; $display("FAIL rd3_ready: got=%b exp=1", b3.req1_ready); end
    for (int c = 1; c <= 6; c++) begin
      nxt();
      b3.req1_valid = 0;
      b3.memrdData = (c == 4) ? 32'hCAFEF00D : 32'hBAD0BAD0;
      mid();
      e_rd = (c == 1); e_rsp = (c == 5); e_busy = (c < 6);
      total++; if (b3.memRd !== e_rd) begin bad++; $display("FAIL rd3_memRd c=%0d: got=%b exp=%b", c, b3.memRd, e_rd); end
      total++; if (b3.rsp1_valid !== e_rsp || busy3 !== e_busy) begin bad++; $display("FAIL rd3_rsp c=%0d: got rsp1=%b busy=%b exp %b %b", c, b3.rsp1_valid, busy3, e_rsp, e_busy); end
      if (c == 1) begin
        total++; if (b3.memAdr !== 32'h40) begin bad++; $display("FAIL rd3_addr: got=%h exp=40", b3.memAdr); end
      end
      if (c == 5) begin
        total++; if (b3.rsp1_rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL rd3_rdata: got=%h exp=cafef00d", b3.rsp1_rdata); end
      end
    end
  endtask

  task automatic test_reset_mid();
    nxt();
    b3.req0_valid = 1; b3.req0_we = 0; b3.req0_addr = 32'h50;
    mid();
    total++; if (b3.req0_ready !== 1'b1) begin bad++; $display("FAIL rm_ready: got=%b exp=1", b3.req0_ready); end
    nxt();
    b3.req0_valid = 0;
    mid();
    total++; if (b3.memRd !== 1'b1) begin bad++; $display("FAIL rm_memRd: got=%b exp=1", b3.memRd); end
    nxt();
    mid();
    total++; if (st3 !== 2'd2) begin bad++; $display("FAIL rm_wait_state: got=%0d exp=2", st3); end
    nxt();
    reset = 1;
    b3.memrdData = 32'h13572468;
    mid();
    total++; if (b3.rsp0_valid !== 1'b0) begin bad++; $display("FAIL rm_rsp_pre: got=%b exp=0", b3.rsp0_valid); end
    nxt();
    mid();
    total++; if (st3 !== 2'd0 || busy3 !== 1'b0 || b3.memRd !== 1'b0) begin bad++; $display("FAIL rm_abort: got st=%0d busy=%b rd=%b exp 0 0 0", st3, busy3, b3.memRd); end
    total++; if (b3.rsp0_valid !== 1'b0 || resetn3 !== 1'b0) begin bad++; $display("FAIL rm_rst_out: got rsp0=%b resetn=%b exp 0 0", b3.rsp0_valid, resetn3); end
    nxt();
    reset = 0;
    b3.req0_valid = 1; b3.req0_we = 1; b3.req0_addr = 32'h60; b3.req0_wdata = 32'h6;
    b3.req1_valid = 1; b3.req1_we = 1; b3.req1_addr = 32'h70; b3.req1_wdata = 32'h7;
    mid();
    total++; if ({b3.req0_ready, b3.req1_ready} !== 2'b10) begin bad++; $display("FAIL rm_prio: got=%b exp=10", {b3.req0_ready, b3.req1_ready}); end
    total++; if (b3.rsp0_valid !== 1'b0) begin bad++; $display("FAIL rm_rsp_post: got=%b exp=0", b3.rsp0_valid); end
    nxt();
    b3.req0_valid = 0; b3.req1_valid = 0;
    mid();
    total++; if (resetn3 !== 1'b1 || b3.memWe !== 1'b1 || b3.memAdr !== 32'h60) begin bad++; $display("FAIL rm_issue: got resetn=%b we=%b adr=%h exp 1 1 60", resetn3, b3.memWe, b3.memAdr); end
    nxt();
    mid();
    total++; if (b3.rsp0_valid !== 1'b1) begin bad++; $display("FAIL rm_rsp: got=%b exp=1", b3.rsp0_valid); end
    nxt();
    mid();
    total++; if (busy3 !== 1'b0) begin bad++; $display("FAIL rm_idle: got=%b exp=0", busy3); end
  endtask

  task automatic test_hold_req1();
    logic e1;
    nxt();
    b1.req0_valid = 1; b1.req0_we = 0; b1.req0_addr = 32'h80; b1.memrdData = 32'h0000_1111;
    mid();
    total++; if ({b1.req0_ready, b1.req1_ready} !== 2'b10) begin bad++; $display("FAIL hold_first: got=%b exp=10", {b1.req0_ready, b1.req1_ready}); end
    for (int c = 1; c <= 5; c++) begin
      nxt();
      b1.req0_valid = 0;
      b1.req1_valid = 1; b1.req1_we = 1; b1.req1_addr = 32'h90; b1.req1_wdata = 32'h55;
      mid();
      e1 = (c == 4);
      total++; if (b1.req1_ready !== e1) begin bad++; $display("FAIL hold_ready1 c=%0d: got=%b exp=%b", c, b1.req1_ready, e1); end
      if (c == 3) begin
        total++; if (b1.rsp0_valid !== 1'b1 || b1.rsp0_rdata !== 32'h0000_1111) begin bad++; $display("FAIL hold_rsp0: got v=%b d=%h exp 1 1111", b1.rsp0_valid, b1.rsp0_rdata); end
      end
      if (c == 5) begin
        total++; if (b1.memWe !== 1'b1 || b1.memAdr !== 32'h90 || b1.memwrData !== 32'h55) begin bad++; $display("FAIL hold_issue1: got we=%b adr=%h data=%h exp 1 90 55", b1.memWe, b1.memAdr, b1.memwrData); end
      end
    end
    nxt();
    b1.req1_valid = 0;
    mid();
    total++; if (b1.rsp1_valid !== 1'b1 || b1.rsp1_rdata !== 32'h0) begin bad++; $display("FAIL hold_rsp1: got v=%b d=%h exp 1 0", b1.rsp1_valid, b1.rsp1_rdata); end
    nxt();
    mid();
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL hold_idle: got=%b exp=0", busy1); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1;
    idle_inputs();
    nxt();
    nxt();
    test_reset();
    test_read_lat1();
    test_write_req1();
    test_round_robin();
    test_read_lat3();
    test_reset_mid();
    test_hold_req1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
